// File: rtl/painterengine_gpu_gpuinfo_pkg.sv
// painterengine_gpu_gpuinfo_pkg
//   Shared constants for the GPU info/telemetry block: host function codes,
//   FSM state encodings, opcode field positions and small field-extraction
//   helpers used by the top level.
package painterengine_gpu_gpuinfo_pkg;

    // Host function codes carried in opcode[7:0]
    localparam logic [7:0] FN_RESET       = 8'h00;
    localparam logic [7:0] FN_GETVERSION  = 8'h01;
    localparam logic [7:0] FN_GETDEBUG    = 8'h02;
    localparam logic [7:0] FN_GETCYCLE_LO = 8'h03;
    localparam logic [7:0] FN_GETCYCLE_HI = 8'h04;
    localparam logic [7:0] FN_GETEVENT    = 8'h05;
    localparam logic [7:0] FN_CLEAREVENT  = 8'h06;
    localparam logic [7:0] FN_GETCHANNELS = 8'h07;

    // FSM states, zero-extended onto the 32-bit state port
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PROCESSING = 2'd1;
    localparam logic [1:0] ST_ERROR      = 2'd2;
    localparam logic [1:0] ST_DONE       = 2'd3;

    // Opcode field positions
    localparam int FUNC_LSB = 0;
    localparam int FUNC_MSB = 7;
    localparam int IDX_LSB  = 8;
    localparam int IDX_MSB  = 15;
    localparam int RSVD_LSB = 16;
    localparam int RSVD_MSB = 31;

    // Function code field of an opcode
    function automatic logic [7:0] op_func(input logic [31:0] op);
        return op[FUNC_MSB:FUNC_LSB];
    endfunction

    // Channel index field of an opcode
    function automatic logic [7:0] op_idx(input logic [31:0] op);
        return op[IDX_MSB:IDX_LSB];
    endfunction

    // Reserved field of an opcode; must be zero for a legal command
    function automatic logic [15:0] op_rsvd(input logic [31:0] op);
        return op[RSVD_MSB:RSVD_LSB];
    endfunction

endpackage

// File: rtl/painterengine_gpu_gpuinfo_if.sv
// painterengine_gpu_gpuinfo_if
//   Host opcode port of the GPU info block.
//   i_wire_opcode  host -> block  command word
//   i_wire_event   host -> block  per-channel increment strobes
//   o_wire_state   block -> host  0 IDLE, 1 PROCESSING, 2 ERROR, 3 DONE
//   o_wire_return  block -> host  result word, valid when state is DONE
interface painterengine_gpu_gpuinfo_if #(
    parameter int EVENT_CHANNELS = 4
);
    logic [31:0]               i_wire_opcode;
    logic [EVENT_CHANNELS-1:0] i_wire_event;
    logic [31:0]               o_wire_state;
    logic [31:0]               o_wire_return;

    modport master (
        output i_wire_opcode,
        output i_wire_event,
        input  o_wire_state,
        input  o_wire_return
    );

    modport slave (
        input  i_wire_opcode,
        input  i_wire_event,
        output o_wire_state,
        output o_wire_return
    );
endinterface

// File: rtl/painterengine_gpu_event_counter.sv
// painterengine_gpu_event_counter
//   One saturating event counter. Counts one per cycle while i_wire_inc is
//   high, sticks at all-ones, and a clear in the same cycle as an increment
//   wins.
//   i_wire_clock   clock, rising edge
//   i_wire_resetn  asynchronous active-low reset
//   i_wire_inc     increment strobe
//   i_wire_clr     synchronous clear
//   o_wire_count   current count
module painterengine_gpu_event_counter #(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     i_wire_clock,
    input  logic                     i_wire_resetn,
    input  logic                     i_wire_inc,
    input  logic                     i_wire_clr,
    output logic [COUNTER_WIDTH-1:0] o_wire_count
);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1'b1);

    logic [COUNTER_WIDTH-1:0] count_r;

    // Saturating count with clear priority over increment
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            count_r <= CNT_ZERO;
        end else if (i_wire_clr) begin
            count_r <= CNT_ZERO;
        end else if (i_wire_inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign o_wire_count = count_r;
endmodule

// File: rtl/painterengine_gpu_gpuinfo_ex.sv
// painterengine_gpu_gpuinfo_ex
//   GPU info/telemetry block on the host opcode port. A non-zero opcode in
//   IDLE is latched and decoded for one PROCESSING cycle; the result is then
//   held in DONE or ERROR until the host writes opcode 0.
//   i_wire_clock   clock, rising edge
//   i_wire_resetn  asynchronous active-low reset
//   host_bus       opcode/event inputs, state/return outputs (slave side)
module painterengine_gpu_gpuinfo_ex
    import painterengine_gpu_gpuinfo_pkg::*;
#(
    parameter logic [31:0] VERSION_WORD   = 32'h00000002,
    parameter logic [31:0] DEBUG_WORD     = 32'h20240612,
    parameter int          EVENT_CHANNELS = 4,
    parameter int          COUNTER_WIDTH  = 32
) (
    input  logic                          i_wire_clock,
    input  logic                          i_wire_resetn,
    painterengine_gpu_gpuinfo_if.slave    host_bus
);
    localparam logic [8:0] NUM_CH = 9'(EVENT_CHANNELS);

    logic [1:0]               state_r;
    logic [31:0]              opcode_r;
    logic [31:0]              ret_r;
    logic [63:0]              cycle_cnt_r;
    // The low half of the snapshot is exactly the word returned by
    // GETCYCLE_LO, so only the high half needs to be kept for GETCYCLE_HI.
    logic [31:0]              snapshot_hi_r;

    logic [COUNTER_WIDTH-1:0] ev_count_s [EVENT_CHANNELS];
    logic [EVENT_CHANNELS-1:0] ev_clr_s;
    logic [COUNTER_WIDTH-1:0] ev_sel_s;
    logic [7:0]               func_s;
    logic [7:0]               idx_s;
    logic                     idx_ok_s;
    logic                     err_s;
    logic                     clr_hit_s;
    logic                     snap_load_s;
    logic [31:0]              result_s;

    // Decode the latched opcode into a result word and error flag
    always_comb begin
        func_s      = op_func(opcode_r);
        idx_s       = op_idx(opcode_r);
        idx_ok_s    = ({1'b0, idx_s} < NUM_CH);
        ev_sel_s    = {COUNTER_WIDTH{1'b0}};
        err_s       = 1'b0;
        clr_hit_s   = 1'b0;
        snap_load_s = 1'b0;
        result_s    = 32'h0000_0000;
        for (int i = 0; i < EVENT_CHANNELS; i++) begin
            if (idx_s == 8'(i)) begin
                ev_sel_s = ev_count_s[i];
            end else begin
                ev_sel_s = ev_sel_s;
            end
        end
        if (op_rsvd(opcode_r) != 16'h0000) begin
            err_s = 1'b1;
        end else begin
            case (func_s)
                FN_RESET:       result_s = 32'h0000_0000;
                FN_GETVERSION:  result_s = VERSION_WORD;
                FN_GETDEBUG:    result_s = DEBUG_WORD;
                FN_GETCYCLE_LO: begin
                    result_s    = cycle_cnt_r[31:0];
                    snap_load_s = 1'b1;
                end
                FN_GETCYCLE_HI: result_s = snapshot_hi_r;
                FN_GETEVENT: begin
                    if (idx_ok_s) begin
                        result_s = 32'(ev_sel_s);
                    end else begin
                        err_s = 1'b1;
                    end
                end
                FN_CLEAREVENT: begin
                    if (idx_ok_s) begin
                        result_s  = 32'(ev_sel_s);
                        clr_hit_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                FN_GETCHANNELS: result_s = 32'(EVENT_CHANNELS);
                default:        err_s = 1'b1;
            endcase
        end
    end

    // Route the clear to the addressed counter only during PROCESSING
    always_comb begin
        ev_clr_s = {EVENT_CHANNELS{1'b0}};
        for (int i = 0; i < EVENT_CHANNELS; i++) begin
            if ((state_r == ST_PROCESSING) && clr_hit_s && (idx_s == 8'(i))) begin
                ev_clr_s[i] = 1'b1;
            end else begin
                ev_clr_s[i] = 1'b0;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < EVENT_CHANNELS; g++) begin : g_ev
            painterengine_gpu_event_counter #(
                .COUNTER_WIDTH (COUNTER_WIDTH)
            ) u_cnt (
                .i_wire_clock  (i_wire_clock),
                .i_wire_resetn (i_wire_resetn),
                .i_wire_inc    (host_bus.i_wire_event[g]),
                .i_wire_clr    (ev_clr_s[g]),
                .o_wire_count  (ev_count_s[g])
            );
        end
    endgenerate

    // Free-running 64-bit cycle counter, wraps naturally
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            cycle_cnt_r <= 64'h0;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 64'h1;
        end
    end

    // Capture the high word alongside a GETCYCLE_LO so LO/HI reads are coherent
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            snapshot_hi_r <= 32'h0;
        end else if ((state_r == ST_PROCESSING) && !err_s && snap_load_s) begin
            snapshot_hi_r <= cycle_cnt_r[63:32];
        end else begin
            snapshot_hi_r <= snapshot_hi_r;
        end
    end

    // Command FSM, opcode latch and registered return word
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_r  <= ST_IDLE;
            opcode_r <= 32'h0;
            ret_r    <= 32'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ret_r <= 32'h0;
                    if (host_bus.i_wire_opcode != 32'h0) begin
                        opcode_r <= host_bus.i_wire_opcode;
                        state_r  <= ST_PROCESSING;
                    end else begin
                        opcode_r <= opcode_r;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_PROCESSING: begin
                    opcode_r <= opcode_r;
                    if (err_s) begin
                        state_r <= ST_ERROR;
                        ret_r   <= 32'h0;
                    end else begin
                        state_r <= ST_DONE;
                        ret_r   <= result_s;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    opcode_r <= opcode_r;
                    if (host_bus.i_wire_opcode == 32'h0) begin
                        state_r <= ST_IDLE;
                        ret_r   <= 32'h0;
                    end else begin
                        state_r <= state_r;
                        ret_r   <= ret_r;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    opcode_r <= 32'h0;
                    ret_r    <= 32'h0;
                end
            endcase
        end
    end

    assign host_bus.o_wire_state  = {30'h0, state_r};
    assign host_bus.o_wire_return = ret_r;
endmodule

// File: tb/tb_painterengine_gpu_gpuinfo_ex.sv
// tb_painterengine_gpu_gpuinfo_ex
//   Directed and randomized checks of the GPU info block against a
//   behavioural model of the host-visible rules (4 channels, 4-bit counters).
module tb_painterengine_gpu_gpuinfo_ex;
    localparam int NCH = 4;
    localparam int CW  = 4;
    localparam int CMAX = 15;

    logic clk;
    logic rst_n;

    painterengine_gpu_gpuinfo_if #(.EVENT_CHANNELS(NCH)) bus ();

    painterengine_gpu_gpuinfo_ex #(
        .VERSION_WORD   (32'h00000002),
        .DEBUG_WORD     (32'h20240612),
        .EVENT_CHANNELS (NCH),
        .COUNTER_WIDTH  (CW)
    ) dut (
        .i_wire_clock  (clk),
        .i_wire_resetn (rst_n),
        .host_bus      (bus)
    );

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    // Model state: event counts, cycle count = ticks + offset, snapshot high word
    int          model_ev [NCH];
    logic [63:0] ticks;
    logic [63:0] offset;
    logic [31:0] model_snap_hi;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count clock edges since reset; the cycle counter model is ticks + offset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ticks <= 64'h0;
        else        ticks <= ticks + 64'h1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected outcome of an opcode from the host-level rules; applies side effects
    task automatic predict(input logic [31:0] op, output logic [31:0] st, output logic [31:0] rv);
        logic [7:0]  f;
        logic [7:0]  ix;
        logic [63:0] c;
        f  = op[7:0];
        ix = op[15:8];
        c  = ticks + offset;
        st = 32'd3;
        rv = 32'd0;
        if (op[31:16] != 16'd0 || f > 8'd7 || ((f == 8'd5 || f == 8'd6) && ix >= 8'(NCH))) begin
            st = 32'd2;
        end else if (f == 8'd1) rv = 32'h00000002;
        else if (f == 8'd2) rv = 32'h20240612;
        else if (f == 8'd3) begin
            rv = c[31:0];
            model_snap_hi = c[63:32];
        end
        else if (f == 8'd4) rv = model_snap_hi;
        else if (f == 8'd5) rv = 32'(model_ev[ix]);
        else if (f == 8'd6) begin
            rv = 32'(model_ev[ix]);
            model_ev[ix] = 0;
        end
        else if (f == 8'd7) rv = 32'(NCH);
        else rv = 32'd0;
    endtask

    // Issue one command from IDLE at a negedge and check all three phases
    task automatic cmd(input string tag, input logic [31:0] op);
        logic [31:0] est;
        logic [31:0] erv;
        bus.i_wire_opcode = op;
        @(negedge clk);
        check({tag, "_proc_state"}, bus.o_wire_state, 32'd1);
        predict(op, est, erv);
        bus.i_wire_opcode = 32'h0000_0123;
        @(negedge clk);
        check({tag, "_state"}, bus.o_wire_state, est);
        check({tag, "_ret"}, bus.o_wire_return, erv);
        bus.i_wire_event = '0;
        @(negedge clk);
        check({tag, "_hold_state"}, bus.o_wire_state, est);
        bus.i_wire_opcode = 32'h0;
        @(negedge clk);
        check({tag, "_idle_state"}, bus.o_wire_state, 32'd0);
        check({tag, "_idle_ret"}, bus.o_wire_return, 32'd0);
    endtask

    // Hold an event mask for n cycles and update the saturating model
    task automatic pulse(input logic [NCH-1:0] mask, input int n);
        bus.i_wire_event = mask;
        repeat (n) @(negedge clk);
        bus.i_wire_event = '0;
        for (int i = 0; i < NCH; i++) begin
            if (mask[i]) model_ev[i] = (model_ev[i] + n > CMAX) ? CMAX : model_ev[i] + n;
        end
    endtask

    initial begin
        logic [31:0] rop;
        rst_n = 1'b0;
        offset = 64'h0;
        model_snap_hi = 32'h0;
        for (int i = 0; i < NCH; i++) model_ev[i] = 0;
        bus.i_wire_opcode = 32'h0;
        bus.i_wire_event  = '0;
        repeat (3) @(negedge clk);
        check("reset_state", bus.o_wire_state, 32'd0);
        check("reset_ret", bus.o_wire_return, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_state", bus.o_wire_state, 32'd0);

        // T1/T2: identification words and error cases
        cmd("getversion", 32'h0000_0001);
        cmd("getdebug", 32'h0000_0002);
        cmd("badfunc", 32'h0000_0009);
        cmd("rsvd", 32'h0001_0001);
        cmd("badidx", 32'h0000_0405);
        cmd("channels", 32'h0000_0007);

        // T3: count, read, clear, re-read
        pulse(4'b0100, 5);
        cmd("getevent2", 32'h0000_0205);
        cmd("clrevent2", 32'h0000_0206);
        cmd("getevent2_after", 32'h0000_0205);

        // T4: saturation, then clear with the strobe still high
        bus.i_wire_event = 4'b0001;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 20; i++) model_ev[0] = (model_ev[0] + 1 > CMAX) ? CMAX : model_ev[0] + 1;
        cmd("getevent0_sat", 32'h0000_0005);
        bus.i_wire_event = 4'b0001;
        model_ev[0] = CMAX;
        cmd("clrevent0_strobe", 32'h0000_0006);
        cmd("getevent0_after", 32'h0000_0005);

        // T5: snapshot coherence across a 32-bit carry, then 64-bit wrap
        force dut.cycle_cnt_r = 64'h0000_0000_FFFF_FFFE;
        #1;
        release dut.cycle_cnt_r;
        offset = 64'h0000_0000_FFFF_FFFE - ticks;
        cmd("cyc_lo_carry", 32'h0000_0003);
        cmd("cyc_hi_carry", 32'h0000_0004);
        @(negedge clk);
        force dut.cycle_cnt_r = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.cycle_cnt_r;
        offset = 64'hFFFF_FFFF_FFFF_FFFE - ticks;
        cmd("cyc_lo_top", 32'h0000_0003);
        cmd("cyc_hi_top", 32'h0000_0004);
        cmd("cyc_lo_wrap", 32'h0000_0003);
        cmd("cyc_hi_wrap", 32'h0000_0004);

        // Randomized traffic against the model
        for (int k = 0; k < 12; k++) begin
            pulse(4'($urandom_range(0, 15)), $urandom_range(0, 7));
            rop = {($urandom_range(0, 7) == 0) ? 16'h0001 : 16'h0000,
                   8'($urandom_range(0, 5)), 8'($urandom_range(1, 9))};
            cmd($sformatf("rand%0d", k), rop);
        end

        // T6: reset while a clear is in PROCESSING
        pulse(4'b1111, 3);
        bus.i_wire_opcode = 32'h0000_0106;
        @(negedge clk);
        check("t6_proc_state", bus.o_wire_state, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_reset_state", bus.o_wire_state, 32'd0);
        check("t6_reset_ret", bus.o_wire_return, 32'd0);
        bus.i_wire_opcode = 32'h0;
        offset = 64'h0;
        model_snap_hi = 32'h0;
        for (int i = 0; i < NCH; i++) model_ev[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmd("t6_ev0", 32'h0000_0005);
        cmd("t6_ev1", 32'h0000_0105);
        cmd("t6_ev2", 32'h0000_0205);
        cmd("t6_ev3", 32'h0000_0305);
        cmd("t6_cyc_hi", 32'h0000_0004);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
